// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing word-aligned imem fetches, buffering {pc, instr} for decode, with redirect flush.
// Ports: i_Clk/i_Rst_n (async active-low); imem o_ImemReq/o_ImemAddr/i_ImemGnt/i_ImemRvalid/i_ImemRdata;
// decode o_InstrValid/o_Instr/o_InstrPc/i_InstrReady; redirect i_Redirect/i_RedirectPc;
// o_FetchCnt (consumed-instruction counter) present only when IFETCH_PERF_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  output logic        o_ImemReq,
  output logic [31:0] o_ImemAddr,
  input  logic        i_ImemGnt,
  input  logic        i_ImemRvalid,
  input  logic [31:0] i_ImemRdata,
  output logic        o_InstrValid,
  output logic [31:0] o_Instr,
  output logic [31:0] o_InstrPc,
  input  logic        i_InstrReady,
  input  logic        i_Redirect,
`ifdef IFETCH_PERF_EN
  input  logic [31:0] i_RedirectPc,
  output logic [31:0] o_FetchCnt
`else
  input  logic [31:0] i_RedirectPc
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;
  state_t        r_State;
  logic [31:0]   r_Pc;
  logic [CW-1:0] r_Outst, r_Discard, r_Cnt;
  logic [AW-1:0] r_Rd, r_Wr, r_TagRd, r_TagWr;
  logic [31:0]   r_FifoPc [DEPTH];
  logic [31:0]   r_FifoInstr [DEPTH];
  logic [31:0]   r_Tag [DEPTH];
  logic          w_Deq, w_Pop, w_Fire, w_Drop, w_Live, w_Push;
  logic [CW:0]   w_Credit;
  logic [CW-1:0] w_OutstLeft, w_OutstNext, w_DiscardNext;
  logic          w_unused;
  assign w_unused     = ^i_RedirectPc[1:0];
  assign o_InstrValid = r_Cnt != '0;
  assign o_Instr      = r_FifoInstr[r_Rd];
  assign o_InstrPc    = r_FifoPc[r_Rd];
  assign o_ImemAddr   = r_Pc;
  // The credit uses the raw handshake; a redirect only cancels the pop's effect on the buffer.
  assign w_Deq    = o_InstrValid && i_InstrReady;
  assign w_Pop    = w_Deq && !i_Redirect;
  assign w_Credit = (CW+1)'(r_Outst) + (CW+1)'(r_Cnt) - (CW+1)'(w_Deq);
  assign o_ImemReq = (r_State == S_RUN) && (w_Credit < (CW+1)'(DEPTH));
  assign w_Fire = o_ImemReq && i_ImemGnt;
  assign w_Drop = i_ImemRvalid && (r_Discard != '0);
  assign w_Live = i_ImemRvalid && (r_Discard == '0);
  assign w_Push = w_Live && !i_Redirect;
  // A live response returning in the redirect cycle is already gone, so it is not counted as stale.
  assign w_OutstLeft   = r_Outst - CW'(w_Live);
  assign w_OutstNext   = i_Redirect ? '0 : w_OutstLeft + CW'(w_Fire);
  assign w_DiscardNext = r_Discard - CW'(w_Drop) + (i_Redirect ? w_OutstLeft + CW'(w_Fire) : '0);
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State   <= S_BOOT;
      r_Pc      <= RESET_PC;
      r_Outst   <= '0;
      r_Discard <= '0;
      r_Cnt     <= '0;
      r_Rd      <= '0;
      r_Wr      <= '0;
      r_TagRd   <= '0;
      r_TagWr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_FifoPc[i]    <= RESET_PC;
        r_FifoInstr[i] <= 32'h0000_0013;
        r_Tag[i]       <= '0;
      end
    end else begin
      // FLUSH holds exactly while stale responses are still owed.
      r_State   <= (w_DiscardNext != '0) ? S_FLUSH : S_RUN;
      r_Outst   <= w_OutstNext;
      r_Discard <= w_DiscardNext;
      r_Pc      <= i_Redirect ? {i_RedirectPc[31:2], 2'b00} : r_Pc + (w_Fire ? 32'd4 : 32'd0);
      if (w_Fire && !i_Redirect) begin
        r_Tag[r_TagWr] <= r_Pc;
        r_TagWr        <= r_TagWr + AW'(1);
      end
      r_TagRd <= i_Redirect ? r_TagWr : r_TagRd + AW'(w_Push);
      if (w_Push) begin
        r_FifoPc[r_Wr]    <= r_Tag[r_TagRd];
        r_FifoInstr[r_Wr] <= i_ImemRdata;
      end
      r_Wr  <= r_Wr + AW'(w_Push);
      r_Rd  <= i_Redirect ? r_Wr : r_Rd + AW'(w_Pop);
      r_Cnt <= i_Redirect ? '0 : r_Cnt + CW'(w_Push) - CW'(w_Pop);
    end
  end
`ifdef IFETCH_PERF_EN
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) o_FetchCnt <= '0;
    else if (w_Pop) o_FetchCnt <= o_FetchCnt + 32'd1;
  end
`endif
  a_no_overflow: assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    !(w_Push && !w_Pop && r_Cnt == CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit streaming, backpressure, redirects and async reset.
module tb_fetch_unit;
  localparam logic [31:0] RST = 32'h0000_0040;
  logic clk = 1'b0, rst_n = 1'b0;
  logic gnt = 1'b1, ready = 1'b1, redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic req, ivalid;
  logic [31:0] addr, instr, ipc;
  logic hold = 1'b0, rnd = 1'b0;
  logic [31:0] q[$];
  int gcnt = 0;
  int checks = 0, errors = 0;
`ifdef IFETCH_PERF_EN
  logic [31:0] fcnt;
  int pops = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pops <= 0;
    else if (ivalid && ready && !redir) pops <= pops + 1;
`endif
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST), .DEPTH(2)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .o_ImemReq(req), .o_ImemAddr(addr), .i_ImemGnt(gnt),
    .i_ImemRvalid(rvalid), .i_ImemRdata(rdata),
    .o_InstrValid(ivalid), .o_Instr(instr), .o_InstrPc(ipc), .i_InstrReady(ready),
    .i_Redirect(redir),
`ifdef IFETCH_PERF_EN
    .i_RedirectPc(redir_pc), .o_FetchCnt(fcnt)
`else
    .i_RedirectPc(redir_pc)
`endif
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // In-order memory: each grant answers one or more cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (req && gnt) q.push_back(addr);
      if (q.size() > 0 && !hold && (!rnd || $urandom_range(0, 1) == 1)) begin
        rvalid <= 1'b1;
        rdata  <= word(q.pop_front());
      end else rvalid <= 1'b0;
    end
  end

  always @(posedge clk) if (rst_n && req && gnt) gcnt <= gcnt + 1;

  task automatic do_reset();
    rst_n = 1'b0; gnt = 1'b1; ready = 1'b1; redir = 1'b0; redir_pc = '0; hold = 1'b0; rnd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", req); end
    checks++; if (addr !== RST) begin errors++; $display("FAIL reset_addr got %h exp %h", addr, RST); end
    checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", ivalid); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr got %h exp 00000013", instr); end
    checks++; if (ipc !== RST) begin errors++; $display("FAIL reset_pc got %h exp %h", ipc, RST); end
  endtask

  task automatic test_stream();
    do_reset();
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL boot_req got %0h exp 0", req); end
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== RST) begin errors++; $display("FAIL first_req got %0h/%h exp 1/%h", req, addr, RST); end
    @(negedge clk);
    checks++; if (ivalid !== 1'b0 || addr !== RST + 4) begin errors++; $display("FAIL cyc2 got valid %0h addr %h exp 0/%h", ivalid, addr, RST + 4); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (ivalid !== 1'b1 || ipc !== RST + 4 * k || instr !== word(RST + 4 * k)) begin
        errors++; $display("FAIL stream%0d got %0h %h %h exp 1 %h %h", k, ivalid, ipc, instr, RST + 4 * k, word(RST + 4 * k));
      end
    end
  endtask

  task automatic test_backpressure();
    int g0;
    do_reset();
    ready = 1'b0;
    g0 = gcnt;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (ivalid !== 1'b1 || ipc !== RST || instr !== word(RST)) begin
          errors++; $display("FAIL hold%0d got %0h %h %h exp 1 %h %h", i, ivalid, ipc, instr, RST, word(RST));
        end
      end
    end
    checks++; if (gcnt - g0 != 2) begin errors++; $display("FAIL bp_grants got %0d exp 2", gcnt - g0); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL bp_req got %0h exp 0", req); end
    ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (ivalid !== 1'b1 || ipc !== RST + 4 * k || instr !== word(RST + 4 * k)) begin
        errors++; $display("FAIL resume%0d got %0h %h exp 1 %h", k, ivalid, ipc, RST + 4 * k);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    int g0;
    bit ok;
    do_reset();
    hold = 1'b1;
    g0 = gcnt;
    repeat (3) @(negedge clk);
    checks++; if (req !== 1'b0 || gcnt - g0 != 2) begin errors++; $display("FAIL inflight got req %0h grants %0d exp 0/2", req, gcnt - g0); end
    redir = 1'b1; redir_pc = 32'h0000_0103;
    @(negedge clk);
    redir = 1'b0;
    checks++; if (req !== 1'b0 || ivalid !== 1'b0) begin errors++; $display("FAIL flush got req %0h valid %0h exp 0/0", req, ivalid); end
    hold = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ivalid) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL redir_timeout got no valid exp valid"); end
    checks++; if (ipc !== 32'h100 || instr !== word(32'h100)) begin errors++; $display("FAIL redir_target got %h %h exp 00000100 %h", ipc, instr, word(32'h100)); end
    @(negedge clk);
    checks++; if (ivalid !== 1'b1 || ipc !== 32'h104) begin errors++; $display("FAIL redir_next got %0h %h exp 1 00000104", ivalid, ipc); end
  endtask

  task automatic test_redirect_pop_grant();
    int g0;
    bit ok;
    do_reset();
    repeat (4) @(negedge clk);
    checks++; if (ivalid !== 1'b1 || ipc !== RST + 4 || req !== 1'b1) begin errors++; $display("FAIL pg_pre got %0h %h %0h exp 1 %h 1", ivalid, ipc, req, RST + 4); end
    g0 = gcnt;
    redir = 1'b1; redir_pc = 32'h0000_0300;
    @(negedge clk);
    redir = 1'b0;
    checks++; if (ivalid !== 1'b0 || gcnt - g0 != 1) begin errors++; $display("FAIL pg_after got valid %0h grants %0d exp 0/1", ivalid, gcnt - g0); end
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ivalid) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL pg_timeout got no valid exp valid"); end
    checks++; if (ipc !== 32'h300 || instr !== word(32'h300)) begin errors++; $display("FAIL pg_target got %h %h exp 00000300 %h", ipc, instr, word(32'h300)); end
    @(negedge clk);
    checks++; if (ivalid !== 1'b1 || ipc !== 32'h304) begin errors++; $display("FAIL pg_next got %0h %h exp 1 00000304", ivalid, ipc); end
`ifdef IFETCH_PERF_EN
    checks++; if (fcnt !== 32'(pops)) begin errors++; $display("FAIL perf_cnt got %0d exp %0d", fcnt, pops); end
`endif
  endtask

  task automatic test_redirect_idle();
    bit ok;
    do_reset();
    ready = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (req !== 1'b0 || ivalid !== 1'b1) begin errors++; $display("FAIL idle_pre got req %0h valid %0h exp 0/1", req, ivalid); end
    redir = 1'b1; redir_pc = 32'h0000_0207;
    @(negedge clk);
    redir = 1'b0;
    checks++; if (req !== 1'b1 || addr !== 32'h204 || ivalid !== 1'b0) begin errors++; $display("FAIL idle_req got %0h %h %0h exp 1 00000204 0", req, addr, ivalid); end
    ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ivalid) begin ok = 1; break; end
    end
    checks++; if (!ok || ipc !== 32'h204) begin errors++; $display("FAIL idle_target got %0h %h exp 1 00000204", ivalid, ipc); end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp;
    int consumed;
    do_reset();
    rnd = 1'b1;
    exp = RST;
    consumed = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gnt = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      if (ivalid && ready) begin
        checks++;
        if (ipc !== exp || instr !== word(exp)) begin errors++; $display("FAIL rnd_pop got %h %h exp %h %h", ipc, instr, exp, word(exp)); end
        exp += 4; consumed++;
      end
    end
    checks++; if (consumed == 0) begin errors++; $display("FAIL rnd_progress got 0 consumed exp >0"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0 || addr !== RST || ivalid !== 1'b0) begin errors++; $display("FAIL async_ctl got %0h %h %0h exp 0 %h 0", req, addr, ivalid, RST); end
    checks++; if (instr !== 32'h13 || ipc !== RST) begin errors++; $display("FAIL async_data got %h %h exp 00000013 %h", instr, ipc, RST); end
    rnd = 1'b0; gnt = 1'b1; ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req !== 1'b1 || addr !== RST) begin errors++; $display("FAIL post_rst_req got %0h %h exp 1 %h", req, addr, RST); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pop_grant();
    test_redirect_idle();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit for the core: owns the program counter and issues word-aligned read requests to instruction memory over a req/gnt/rvalid interface. It buffers returned words with their PCs and presents them to decode (the control unit's `i_Instr` source) through a valid/ready handshake. It also applies taken-branch/jump redirects by flushing buffered and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: instruction buffer entries; power of 2, ≥2.
- `i_Clk` in 1: clock, all state on rising edge.
- `i_Rst_n` in 1: asynchronous active-low reset.
- `o_ImemReq` out 1: fetch request valid.
- `o_ImemAddr` out 32: fetch address, bits [1:0] always 0.
- `i_ImemGnt` in 1: request accepted this cycle; address is sampled only when `o_ImemReq && i_ImemGnt`.
- `i_ImemRvalid` in 1: read data valid; in order, ≥1 cycle after its grant.
- `i_ImemRdata` in 32: instruction word.
- `o_InstrValid` out 1: `o_Instr`/`o_InstrPc` valid.
- `o_Instr` out 32: instruction to decode.
- `o_InstrPc` out 32: address of `o_Instr`.
- `i_InstrReady` in 1: decode consumes when `o_InstrValid && i_InstrReady`.
- `i_Redirect` in 1: taken branch/jump, one-cycle pulse.
- `i_RedirectPc` in 32: redirect target; bits [1:0] ignored (forced 00).

## Operation
- Registers: PC, `r_Outst` (granted, not yet returned), `r_Discard` (stale in-flight responses to drop), FIFO of {pc, instr}, FSM.
- FSM states:
  - S_BOOT: entered on reset; no request; next cycle → S_RUN.
  - S_RUN: `o_ImemReq` = (`r_Outst` + FIFO count − pop this cycle) < DEPTH; on grant PC += 4, `r_Outst`++.
  - S_FLUSH: no requests; entered on redirect when stale responses remain (`r_Discard` ≠ 0 after update). Returns to S_RUN in the cycle `r_Discard` reaches 0.
- Response handling: on `i_ImemRvalid`, if `r_Discard` > 0 then decrement and drop; otherwise push {pc-of-request, word} and decrement `r_Outst`. The request PC travels in a small in-order tag queue of DEPTH entries.
- Redirect (any state):
  - PC ← `{i_RedirectPc[31:2],2'b00}`; FIFO emptied.
  - `r_Discard` += `r_Outst` (+1 if a grant occurs the same cycle); `r_Outst` ← 0.
  - A pop in the same cycle is ignored, so the redirect wins.
  - A redirect during S_FLUSH accumulates stale count and updates PC.
- Push and pop in the same cycle leave the FIFO count unchanged. FIFO never overflows by the credit rule; an overflow is an assertion failure in simulation.
- Ungranted request: the address may change (e.g. on redirect); memory is not required to see a stable address before grant.

## Timing
- Reset values:
  - `o_ImemReq` 0, `o_ImemAddr` RESET_PC.
  - `o_InstrValid` 0, `o_Instr` 32'h0000_0013 (NOP), `o_InstrPc` RESET_PC.
  - Counters 0, FSM S_BOOT.
- First request: cycle 1 after `i_Rst_n` deasserts.
- Latency: rvalid in cycle N → `o_InstrValid` in cycle N+1 (registered FIFO head, show-ahead).
- Throughput: 1 instr/cycle with `i_ImemGnt`=1, 1-cycle rvalid, ready held high.
- Redirect in cycle N with nothing in flight: request to the target in cycle N+1; `o_InstrValid` low in N+1.
- `o_InstrValid`, `o_Instr` and `o_InstrPc` hold stable while valid and not ready.
- Reset mid-operation clears all state immediately; later responses for pre-reset requests are the memory's responsibility (the memory is reset with the same reset).

## Configuration
- `IFETCH_PERF_EN`:
  - Defined: adds output `o_FetchCnt` (32, reset 0). It increments once per consumed instruction, wraps at 2^32, and does not count flushed words.
  - Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release, gnt=1, 1-cycle memory returning addr-derived words: `o_InstrPc` = 0,4,8,… on consecutive cycles from cycle 3; `o_Instr` matches.
- Ready held low 10 cycles: at most DEPTH=2 requests are granted, output is stable at PC 0; releasing ready resumes 1/cycle without loss.
- Redirect to 32'h0000_0103 while 2 requests are in flight: both stale words dropped, next valid `o_InstrPc` = 32'h100, FSM passes through S_FLUSH.
- Redirect coincident with a pop and a grant: popped instruction not repeated, granted word discarded, fetch resumes at target.
- Assert `i_Rst_n`=0 mid-stream with random gnt/rvalid: all outputs return to reset values asynchronously, first post-reset request is RESET_PC.
- With `IFETCH_PERF_EN`: 5 consumes plus 1 flushed word → `o_FetchCnt` = 5.
